// File: rtl/m2_bus_write_decoder.sv
// Bus front end: synchronises M2, rejects short pulses, latches the CPU bus late in the
// high phase and emits one-cycle write strobes, a per-cycle tick and a bus-idle flag.
module m2_bus_write_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned M2_MIN_HIGH = 8,
    parameter int unsigned SAMPLE_DLY  = 12,
    parameter int unsigned M2_TIMEOUT  = 2048
) (
    input  logic        osc50,
    input  logic        m2_rst,
    input  logic        m2,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data,
    output logic        wr_rom,
    output logic        wr_5000,
    output logic        wr_5001,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        cpu_tick,
    output logic        cpu_idle
);

    localparam int unsigned HW = $clog2(SAMPLE_DLY + 1);
    localparam int unsigned TW = $clog2(M2_TIMEOUT + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StHigh  = 2'd1;
    localparam logic [1:0] StArmed = 2'd2;
    localparam logic [1:0] StFire  = 2'd3;

    logic [SYNC_STAGES-1:0] m2_sync_q, m2_sync_d;
    logic                   m2_s;
    logic [1:0]             state_q, state_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [14:0]            addr_sh_q, addr_sh_d;
    logic [7:0]             data_sh_q, data_sh_d;
    logic                   rw_sh_q, rw_sh_d;
    logic                   romsel_sh_q, romsel_sh_d;
    logic                   wr_rom_q, wr_rom_d;
    logic                   wr_5000_q, wr_5000_d;
    logic                   wr_5001_q, wr_5001_d;
    logic                   cpu_tick_q, cpu_tick_d;
    logic [14:0]            wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   go_armed;
    logic                   is_write;

    assign m2_sync_d = {m2_sync_q[SYNC_STAGES-2:0], m2};
    assign m2_s      = m2_sync_q[SYNC_STAGES-1];
    assign go_armed  = (hcnt_q == HW'(SAMPLE_DLY)) && (hcnt_q >= HW'(M2_MIN_HIGH));

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        rw_sh_d     = rw_sh_q;
        romsel_sh_d = romsel_sh_q;
        wr_rom_d    = 1'b0;
        wr_5000_d   = 1'b0;
        wr_5001_d   = 1'b0;
        cpu_tick_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        is_write    = 1'b0;
        tcnt_d      = (tcnt_q == TW'(M2_TIMEOUT)) ? tcnt_q : tcnt_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (m2_s) begin
                    state_d = StHigh;
                    hcnt_d  = HW'(1);
                end
            end
            StHigh: begin
                if (!m2_s) begin
                    state_d = StIdle;
                end else if (go_armed) begin
                    state_d = StArmed;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            StArmed: begin
                if (m2_s) begin
                    // Keep resampling so the value seen just before the fall wins.
                    addr_sh_d   = cpu_addr_in;
                    data_sh_d   = cpu_data;
                    rw_sh_d     = cpu_rw_in;
                    romsel_sh_d = romsel;
                end else begin
                    // Outputs are registered here so they are high during the FIRE cycle.
                    state_d    = StFire;
                    cpu_tick_d = 1'b1;
                    wr_rom_d   = !rw_sh_q && !romsel_sh_q;
                    wr_5000_d  = !rw_sh_q && romsel_sh_q && (addr_sh_q == 15'h5000);
                    wr_5001_d  = !rw_sh_q && romsel_sh_q && (addr_sh_q == 15'h5001);
                    is_write   = wr_rom_d || wr_5000_d || wr_5001_d;
                    if (is_write) begin
                        wr_addr_d = addr_sh_q;
                        wr_data_d = data_sh_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge osc50 or negedge m2_rst) begin
        if (!m2_rst) begin
            m2_sync_q   <= '0;
            state_q     <= StIdle;
            hcnt_q      <= '0;
            tcnt_q      <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            rw_sh_q     <= 1'b1;
            romsel_sh_q <= 1'b1;
            wr_rom_q    <= 1'b0;
            wr_5000_q   <= 1'b0;
            wr_5001_q   <= 1'b0;
            cpu_tick_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            m2_sync_q   <= m2_sync_d;
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            tcnt_q      <= tcnt_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            rw_sh_q     <= rw_sh_d;
            romsel_sh_q <= romsel_sh_d;
            wr_rom_q    <= wr_rom_d;
            wr_5000_q   <= wr_5000_d;
            wr_5001_q   <= wr_5001_d;
            cpu_tick_q  <= cpu_tick_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_rom   = wr_rom_q;
    assign wr_5000  = wr_5000_q;
    assign wr_5001  = wr_5001_q;
    assign cpu_tick = cpu_tick_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_idle = (tcnt_q == TW'(M2_TIMEOUT));

endmodule

// File: tb/tb_m2_bus_write_decoder.sv
// Self-checking bench: bus cycles push expected events to a scoreboard that a negedge
// monitor pops whenever the decoder emits a tick or strobe.
module tb_m2_bus_write_decoder;

    localparam int LATENCY = 3;

    typedef struct packed {
        logic        rom;
        logic        w0;
        logic        w1;
        logic [14:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m2 = 1'b0;
    logic        romsel = 1'b1;
    logic        cpu_rw_in = 1'b1;
    logic [14:0] cpu_addr_in = '0;
    logic [7:0]  cpu_data = '0;
    logic        wr_rom, wr_5000, wr_5001, cpu_tick, cpu_idle;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int fall_cyc = 0;
    ev_t sb[$];
    logic [14:0] last_addr = '0;
    logic [7:0]  last_data = '0;

    m2_bus_write_decoder dut (
        .osc50       (clk),
        .m2_rst      (rst_n),
        .m2          (m2),
        .romsel      (romsel),
        .cpu_rw_in   (cpu_rw_in),
        .cpu_addr_in (cpu_addr_in),
        .cpu_data    (cpu_data),
        .wr_rom      (wr_rom),
        .wr_5000     (wr_5000),
        .wr_5001     (wr_5001),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cpu_tick    (cpu_tick),
        .cpu_idle    (cpu_idle)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard monitor
    ev_t e;
    always @(negedge clk) begin
        if (rst_n && (cpu_tick || wr_rom || wr_5000 || wr_5001)) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event: tick=%b rom=%b 5000=%b 5001=%b, none expected",
                         cpu_tick, wr_rom, wr_5000, wr_5001);
            end else begin
                n_pass++;
                e = sb.pop_front();
                n_checks++;
                if (cpu_tick !== 1'b1)
                    $display("FAIL tick: got %b want 1", cpu_tick);
                else n_pass++;
                n_checks++;
                if ({wr_rom, wr_5000, wr_5001} !== {e.rom, e.w0, e.w1})
                    $display("FAIL strobes: got %b%b%b want %b%b%b",
                             wr_rom, wr_5000, wr_5001, e.rom, e.w0, e.w1);
                else n_pass++;
                n_checks++;
                if (wr_addr !== e.addr || wr_data !== e.data)
                    $display("FAIL addr_data: got %h/%h want %h/%h",
                             wr_addr, wr_data, e.addr, e.data);
                else n_pass++;
                n_checks++;
                if (cyc - fall_cyc !== LATENCY)
                    $display("FAIL latency: got %0d want %0d", cyc - fall_cyc, LATENCY);
                else n_pass++;
            end
        end
    end

    task automatic bus_cycle(input logic rw, input logic rs, input logic [14:0] a,
                             input logic [7:0] early, input logic [7:0] d,
                             input int high, input int sw_at);
        ev_t x;
        @(negedge clk);
        cpu_rw_in   = rw;
        romsel      = rs;
        cpu_addr_in = a;
        cpu_data    = early;
        if (high >= 15) begin
            x.rom  = !rw && !rs;
            x.w0   = !rw && rs && (a == 15'h5000);
            x.w1   = !rw && rs && (a == 15'h5001);
            if (x.rom || x.w0 || x.w1) begin
                last_addr = a;
                last_data = d;
            end
            x.addr = last_addr;
            x.data = last_data;
            sb.push_back(x);
        end
        repeat (3) @(negedge clk);
        m2 = 1'b1;
        repeat (sw_at) @(negedge clk);
        cpu_data = d;
        repeat (high - sw_at) @(negedge clk);
        m2 = 1'b0;
        fall_cyc = cyc;
        repeat (5) @(negedge clk);
        cpu_rw_in   = 1'b1;
        romsel      = 1'b1;
        cpu_data    = 8'($urandom);
        cpu_addr_in = 15'($urandom);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL %s_drain: %0d events pending, want 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({wr_rom, wr_5000, wr_5001, cpu_tick, cpu_idle} !== 5'b0 ||
            wr_addr !== 15'h0 || wr_data !== 8'h0)
            $display("FAIL %s: strobes/tick/idle=%b%b%b%b%b addr=%h data=%h want all 0", name,
                     wr_rom, wr_5000, wr_5001, cpu_tick, cpu_idle, wr_addr, wr_data);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("after_release");
    endtask

    task automatic test_rom_write();
        bus_cycle(1'b0, 1'b0, 15'h0000, 8'hFF, 8'h5A, 15, 4);
        // romsel low wins over a $5000-looking address
        bus_cycle(1'b0, 1'b0, 15'h5000, 8'h00, 8'h3C, 15, 4);
        // data changing while armed: the last sample before the fall counts
        bus_cycle(1'b0, 1'b0, 15'h7FFF, 8'h11, 8'hA7, 20, 17);
        check_drained("rom_write");
    endtask

    task automatic test_mc_writes();
        bus_cycle(1'b0, 1'b1, 15'h5000, 8'hFF, 8'h13, 15, 4);
        bus_cycle(1'b0, 1'b1, 15'h5001, 8'hFF, 8'h00, 15, 4);
        check_drained("mc_writes");
    endtask

    task automatic test_no_strobe();
        bus_cycle(1'b1, 1'b0, 15'h4000, 8'h99, 8'h99, 15, 4);
        bus_cycle(1'b0, 1'b1, 15'h6000, 8'hEE, 8'hEE, 15, 4);
        bus_cycle(1'b0, 1'b1, 15'h5002, 8'h44, 8'h44, 15, 4);
        bus_cycle(1'b1, 1'b1, 15'h5000, 8'h55, 8'h55, 15, 4);
        check_drained("no_strobe");
    endtask

    task automatic test_glitch();
        bus_cycle(1'b0, 1'b0, 15'h0000, 8'h66, 8'h66, 5, 2);
        bus_cycle(1'b0, 1'b1, 15'h5000, 8'h77, 8'h77, 7, 2);
        // a following good cycle proves the FSM returned to idle
        bus_cycle(1'b0, 1'b1, 15'h5001, 8'hFF, 8'h81, 15, 4);
        check_drained("glitch");
    endtask

    task automatic test_timeout();
        repeat (1985) @(negedge clk);
        n_checks++;
        if (cpu_idle !== 1'b0) $display("FAIL idle_early: got %b want 0", cpu_idle);
        else n_pass++;
        repeat (70) @(negedge clk);
        n_checks++;
        if (cpu_idle !== 1'b1) $display("FAIL idle_set: got %b want 1", cpu_idle);
        else n_pass++;
        bus_cycle(1'b1, 1'b0, 15'h4000, 8'h00, 8'h00, 15, 4);
        n_checks++;
        if (cpu_idle !== 1'b0) $display("FAIL idle_clear: got %b want 0", cpu_idle);
        else n_pass++;
        check_drained("timeout");
    endtask

    task automatic test_reset_armed();
        bus_cycle(1'b0, 1'b0, 15'h0123, 8'hC3, 8'hC3, 15, 4);
        @(negedge clk);
        cpu_rw_in   = 1'b0;
        romsel      = 1'b0;
        cpu_addr_in = 15'h0000;
        cpu_data    = 8'h77;
        repeat (3) @(negedge clk);
        m2 = 1'b1;
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_armed");
        repeat (2) @(negedge clk);
        m2 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_addr = '0;
        last_data = '0;
        repeat (15) @(negedge clk);
        check_outputs_zero("no_strobe_after_reset");
        check_drained("reset_armed");
        bus_cycle(1'b0, 1'b0, 15'h2468, 8'hFF, 8'h9D, 15, 4);
        check_drained("post_reset_write");
    endtask

    initial begin
        test_reset();
        test_rom_write();
        test_mc_writes();
        test_no_strobe();
        test_glitch();
        test_timeout();
        test_reset_armed();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
